// File: rtl/aclk_controller_if.sv
// Alarm clock controller bus: keypad/button/tick inputs toward the
// controller and display/load strobes back out to the datapath.
interface aclk_controller_if;
    logic       one_second;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key;
    logic       show_new_time;
    logic       show_alarm;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;

    // Driver side: the keypad, buttons and seconds tick generator.
    modport master (
        output one_second, alarm_button, time_button, key,
        input  show_new_time, show_alarm, shift, load_new_a, load_new_c
    );

    // Controller side.
    modport slave (
        input  one_second, alarm_button, time_button, key,
        output show_new_time, show_alarm, shift, load_new_a, load_new_c
    );
endinterface

// File: rtl/aclk_controller.sv
// Alarm clock controller: sequences keypad entry into a key buffer and
// decides whether the entered digits load the alarm or the current time.
// Abandons entry after TIMEOUT seconds of inactivity.
module aclk_controller #(
    parameter logic [3:0] NOKEY   = 4'd10,
    parameter int         TIMEOUT = 10
) (
    input logic              clock,
    input logic              reset,
    aclk_controller_if.slave bus
);

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SHOW_ALARM = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] count;
    logic       key_lock;
    logic       load_a_next;
    logic       load_c_next;
    logic       timed_out;
    logic       key_down;

    assign key_down  = (bus.key != NOKEY);
    assign timed_out = (count == 4'(TIMEOUT - 1)) && bus.one_second;

    // Next-state and load-request decode; buttons and keys beat a coincident timeout.
    always_comb begin
        next_state  = state;
        load_a_next = 1'b0;
        load_c_next = 1'b0;
        case (state)
            SHOW_TIME: begin
                if (bus.alarm_button)
                    next_state = SHOW_ALARM;
                else if (key_down && !key_lock)
                    next_state = KEY_STORED;
            end
            KEY_STORED: next_state = KEY_WAITED;
            KEY_WAITED: begin
                if (!key_down)
                    next_state = KEY_ENTRY;
                else if (timed_out)
                    next_state = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (bus.alarm_button) begin
                    next_state  = SHOW_TIME;
                    load_a_next = 1'b1;
                end else if (bus.time_button) begin
                    next_state  = SHOW_TIME;
                    load_c_next = 1'b1;
                end else if (key_down)
                    next_state = KEY_STORED;
                else if (timed_out)
                    next_state = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button)
                    next_state = SHOW_TIME;
            end
            default: next_state = SHOW_TIME;
        endcase
    end

    // State, inactivity counter, held-key lockout and registered Moore outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= SHOW_TIME;
            count             <= 4'd0;
            key_lock          <= 1'b0;
            bus.shift         <= 1'b0;
            bus.show_new_time <= 1'b0;
            bus.show_alarm    <= 1'b0;
            bus.load_new_a    <= 1'b0;
            bus.load_new_c    <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == KEY_WAITED || state == KEY_ENTRY) && next_state == state) begin
                if (bus.one_second && count != 4'(TIMEOUT))
                    count <= count + 4'd1;
            end else begin
                count <= 4'd0;
            end
            // A key still held when entry times out must be released before it counts again.
            key_lock          <= key_down && (key_lock || (state == KEY_WAITED && timed_out));
            bus.shift         <= (next_state == KEY_STORED);
            bus.show_new_time <= (next_state == KEY_STORED) || (next_state == KEY_WAITED) ||
                                 (next_state == KEY_ENTRY);
            bus.show_alarm    <= (next_state == SHOW_ALARM);
            bus.load_new_a    <= load_a_next;
            bus.load_new_c    <= load_c_next;
        end
    end

endmodule

// File: tb/tb_aclk_controller.sv
// Directed testbench for the alarm clock controller.
module tb_aclk_controller;

    localparam logic [3:0] NOKEY = 4'd10;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    aclk_controller_if bus ();

    aclk_controller #(.NOKEY(NOKEY), .TIMEOUT(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // 10-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Output vector ordering: {show_new_time, show_alarm, shift, load_new_a, load_new_c}.
    function automatic logic [4:0] outs();
        return {bus.show_new_time, bus.show_alarm, bus.shift, bus.load_new_a, bus.load_new_c};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.one_second   = 1'b0;
        bus.alarm_button = 1'b0;
        bus.time_button  = 1'b0;
        bus.key          = NOKEY;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Walks a fresh key press from SHOW_TIME into KEY_ENTRY.
    task automatic enter_entry(input logic [3:0] k);
        bus.key = k;
        step();
        bus.key = NOKEY;
        step();
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.one_second = 1'b1;
            step();
            bus.one_second = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.key = 4'd5;
        reset   = 1'b0;
        step();
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b want=%b", outs(), 5'b00000);
        end
        step();
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_hold got=%b want=%b", outs(), 5'b00000);
        end
        bus.key = NOKEY;
        reset   = 1'b1;
        step();
    endtask

    task automatic test_key_sequence();
        logic [3:0] k [10] = '{4'd5, 4'd5, 4'd5, NOKEY, 4'd6, NOKEY, NOKEY, NOKEY, NOKEY, NOKEY};
        logic       t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0] e [10] = '{5'b10100, 5'b10000, 5'b10000, 5'b10000, 5'b10100,
                               5'b10000, 5'b10000, 5'b00001, 5'b00000, 5'b00000};
        for (int i = 0; i < 10; i++) begin
            bus.key         = k[i];
            bus.time_button = t[i];
            step();
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("[TB] FAIL key_seq[%0d] got=%b want=%b", i, outs(), e[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_alarm_view();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            logic [4:0] want;
            bus.alarm_button = (i < 4);
            want = (i < 4) ? 5'b01000 : 5'b00000;
            step();
            checks++;
            if (outs() !== want) begin
                failures++;
                $display("[TB] FAIL alarm_view[%0d] got=%b want=%b", i, outs(), want);
            end
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        enter_entry(4'd3);
        for (int i = 1; i <= 10; i++) begin
            logic [4:0] want;
            want = (i < 10) ? 5'b10000 : 5'b00000;
            bus.one_second = 1'b1;
            step();
            bus.one_second = 1'b0;
            if (i >= 9) begin
                checks++;
                if (outs() !== want) begin
                    failures++;
                    $display("[TB] FAIL timeout_tick%0d got=%b want=%b", i, outs(), want);
                end
            end
            step();
        end
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL timeout_after got=%b want=%b", outs(), 5'b00000);
        end
    endtask

    task automatic test_priority();
        // Alarm button coinciding with the final tick loads the alarm.
        enter_entry(4'd3);
        ticks(9);
        bus.one_second   = 1'b1;
        bus.alarm_button = 1'b1;
        step();
        checks++;
        if (outs() !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL prio_alarm got=%b want=%b", outs(), 5'b00010);
        end
        idle_inputs();
        step();
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL prio_alarm_once got=%b want=%b", outs(), 5'b00000);
        end
        // Both buttons together: alarm wins, only load_new_a.
        enter_entry(4'd8);
        bus.alarm_button = 1'b1;
        bus.time_button  = 1'b1;
        step();
        checks++;
        if (outs() !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL prio_both_buttons got=%b want=%b", outs(), 5'b00010);
        end
        idle_inputs();
        step();
        // New key coinciding with the final tick re-stores instead of timing out.
        enter_entry(4'd1);
        ticks(9);
        bus.one_second = 1'b1;
        bus.key        = 4'd2;
        step();
        checks++;
        if (outs() !== 5'b10100) begin
            failures++;
            $display("[TB] FAIL prio_key_vs_timeout got=%b want=%b", outs(), 5'b10100);
        end
        do_reset();
    endtask

    task automatic test_held_key();
        bus.key = 4'd4;
        step();
        step();
        ticks(10);
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL held_timeout got=%b want=%b", outs(), 5'b00000);
        end
        step();
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL held_no_restore got=%b want=%b", outs(), 5'b00000);
        end
        bus.key = NOKEY;
        step();
        bus.key = 4'd4;
        step();
        checks++;
        if (outs() !== 5'b10100) begin
            failures++;
            $display("[TB] FAIL held_repress got=%b want=%b", outs(), 5'b10100);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_entry();
        bus.key = 4'd7;
        step();
        step();
        checks++;
        if (outs() !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL mid_waited got=%b want=%b", outs(), 5'b10000);
        end
        reset = 1'b0;
        step();
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL mid_reset got=%b want=%b", outs(), 5'b00000);
        end
        reset   = 1'b1;
        bus.key = NOKEY;
        bus.time_button = 1'b1;
        step();
        checks++;
        if (outs() !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL mid_no_load got=%b want=%b", outs(), 5'b00000);
        end
        idle_inputs();
        step();
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_key_sequence();
        test_alarm_view();
        test_timeout();
        test_priority();
        test_held_key();
        test_reset_mid_entry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
